spi_peripheral_controller: RTL
==============================

SPI_PERIPHERAL_CONTROLLER -- requirements
Module: spi_peripheral_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on spi_sck, spi_cs, spi_mosi.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF: byte shifted out when the TX FIFO is empty.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port spi_sck  in  1  external master clock, asynchronous to clk.
REQ-006 SHALL have port spi_cs  in  1  chip select, active low, asynchronous.
REQ-007 SHALL have port spi_mosi  in  1  serial data from master, asynchronous.
REQ-008 SHALL have port spi_miso  out  1  serial data to master.
REQ-009 SHALL have port spi_miso_oe  out  1  MISO drive enable, high while selected.
REQ-010 SHALL have ports tx_wr  in  1 and tx_din  in  8: push a byte to the TX FIFO.
REQ-011 SHALL have ports tx_full  out  1 and tx_empty  out  1: TX FIFO status.
REQ-012 SHALL have ports rx_rd  in  1 and rx_dout  out  8: pop the RX FIFO; rx_dout is show-ahead.
REQ-013 SHALL have ports rx_avail  out  1 and rx_full  out  1: RX FIFO status.
REQ-014 SHALL have ports overrun  out  1, underrun  out  1, err_clr  in  1: sticky error flags and their clear.
REQ-015 SHALL have port busy  out  1  high while the synchronized spi_cs is low.

Function
REQ-016 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, back-to-back bytes within one CS assertion.
REQ-017 SHALL pass spi_sck/spi_cs/spi_mosi through SYNC_STAGES flops and detect edges from the last two synchronized samples; supported spi_sck frequency is at most clk/8.
REQ-018 SHALL use the FSM IDLE -> SHIFT -> IDLE; IDLE->SHIFT on the synchronized spi_cs falling edge; any state -> IDLE on the synchronized spi_cs rising edge.
REQ-019 On entry to SHIFT, SHALL pop one TX byte into the TX shift register and drive its bit 7 on spi_miso; if the TX FIFO is empty it SHALL load IDLE_BYTE and set underrun.
REQ-020 On each synchronized sck rising edge, SHALL shift the synchronized spi_mosi into the RX shift register LSB and increment a 3-bit bit counter.
REQ-021 On each synchronized sck falling edge, SHALL shift the TX register left and drive the next bit; after bit 0 it SHALL instead present bit 7 of the next byte.
REQ-022 On the 8th rising edge (counter wraps 7->0), SHALL push the assembled byte to the RX FIFO in the same cycle and pop the next TX byte (or IDLE_BYTE with underrun) for the following falling edge.
REQ-023 A byte SHALL be visible on rx_avail/rx_dout no later than SYNC_STAGES+2 clk cycles after the 8th spi_sck rising edge at the pin.
REQ-024 If the RX FIFO is full at push, the byte SHALL be dropped, overrun set, and FIFO contents kept.
REQ-025 Simultaneous rx_rd and internal push on a full RX FIFO SHALL perform both; no overrun.
REQ-026 tx_wr while tx_full SHALL be ignored with no flag; rx_rd while empty SHALL be ignored.
REQ-027 A CS deassert mid-byte SHALL discard the partial RX byte (no push), clear the bit counter, and discard the loaded TX byte.
REQ-028 err_clr SHALL clear overrun and underrun; a same-cycle set event SHALL win over err_clr.
REQ-029 spi_miso_oe SHALL equal busy; spi_miso SHALL be 0 in IDLE.

Reset
REQ-030 Rst SHALL force IDLE, empty both FIFOs, clear the counter, shift registers and synchronizers (spi_cs synchronizers to 1), and drive spi_miso=0, spi_miso_oe=0, busy=0, overrun=0, underrun=0, tx_empty=1, tx_full=0, rx_avail=0, rx_full=0, rx_dout=0.
REQ-031 Rst asserted mid-frame SHALL abort the frame identically; after release, the block SHALL wait for a fresh spi_cs falling edge.

Structure
REQ-032 SHALL place the FSM state enum, FIFO depth constant (16) and frame width (8) in the shared SPI package.
REQ-033 SHALL instantiate the existing sync_fifo twice (TX and RX, 8-bit, 16 deep); no other sub-module.

Verification
REQ-034 SHALL cover: preload TX 8'hA5; master sends 8'h3C with sck=clk/8 -> master receives 8'hA5, rx_dout=8'h3C, rx_avail=1.
REQ-035 SHALL cover: empty TX FIFO, one-byte transfer -> master receives 8'hFF, underrun=1; err_clr -> underrun=0.
REQ-036 SHALL cover: 17 bytes 8'h00..8'h10 with no rx_rd -> rx_full=1, overrun=1, 16 pops return 8'h00..8'h0F.
REQ-037 SHALL cover: CS deasserted after 5 bits of 8'hF0 -> no RX push, next full frame 8'h81 received correctly.
REQ-038 SHALL cover: 3-byte burst 8'h11,8'h22,8'h33 each way in one CS assertion -> both sides see the exact sequences.
REQ-039 SHALL cover: Rst pulse mid-byte -> all REQ-030 values next cycle; following transfer of 8'h5A is correct.

Source files
------------

// File: rtl/spi_peripheral_controller_pkg.sv
// Shared SPI peripheral types and sizing: FSM state encoding, frame width, FIFO depth.
package spi_peripheral_controller_pkg;

  localparam int unsigned FRAME_W    = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_W);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered show-ahead head and registered full/empty flags.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_ok, rd_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_ok    = wr_en && (!full_q || rd_en);
    rd_ok    = rd_en && !empty_q;
    wr_ptr_d = wr_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    // Next head: bypass the write data when the new head is the slot being written now.
    if (count_d == '0) begin
      rd_data_d = '0;
    end else if (wr_ok && (rd_ptr_d == wr_ptr_q)) begin
      rd_data_d = wr_data;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/spi_peripheral_controller.sv
// SPI mode-0 peripheral: oversamples the master's sck/cs/mosi in the clk domain,
// shifts MSB-first 8-bit frames, and buffers both directions in 16-deep FIFOs.
module spi_peripheral_controller
  import spi_peripheral_controller_pkg::*;
#(
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [FRAME_W-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               spi_sck,
  input  logic               spi_cs,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_miso_oe,
  input  logic               tx_wr,
  input  logic [FRAME_W-1:0] tx_din,
  output logic               tx_full,
  output logic               tx_empty,
  input  logic               rx_rd,
  output logic [FRAME_W-1:0] rx_dout,
  output logic               rx_avail,
  output logic               rx_full,
  output logic               overrun,
  output logic               underrun,
  input  logic               err_clr,
  output logic               busy
);

  localparam int unsigned        FLUSH_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [FLUSH_W-1:0]     flush_q, flush_d;
  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]     tx_sr_q, tx_sr_d;
  logic [FRAME_W-1:0]     rx_sr_q, rx_sr_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;

  logic                   sck_s, cs_s, mosi_s, armed;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic                   tx_pop, rx_push, rx_empty;
  logic                   underrun_set, overrun_set;
  logic [FRAME_W-1:0]     tx_head, tx_load, rx_byte;

  // Synchronizers, edge detection; edges are ignored until the chain is flushed after reset
  // so a chip select already held low does not look like a fresh falling edge.
  always_comb begin
    sck_sync_d  = SYNC_STAGES'({sck_sync_q, spi_sck});
    cs_sync_d   = SYNC_STAGES'({cs_sync_q, spi_cs});
    mosi_sync_d = SYNC_STAGES'({mosi_sync_q, spi_mosi});
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    flush_d     = (flush_q != '0) ? flush_q - FLUSH_W'(1) : flush_q;
    armed       = (flush_q == '0);
    sck_rise    = armed & sck_s & ~sck_prev_q;
    sck_fall    = armed & ~sck_s & sck_prev_q;
    cs_fall     = armed & ~cs_s & cs_prev_q;
    cs_rise     = armed & cs_s & ~cs_prev_q;
    busy_d      = ~cs_s;
  end

  // Frame FSM and shift datapath.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    miso_d       = miso_q;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    underrun_set = 1'b0;
    tx_load      = tx_empty ? IDLE_BYTE : tx_head;
    rx_byte      = {rx_sr_q[FRAME_W-2:0], mosi_s};

    unique case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (cs_fall) begin
          state_d      = ST_SHIFT;
          tx_pop       = ~tx_empty;
          underrun_set = tx_empty;
          tx_sr_d      = tx_load;
          miso_d       = tx_load[FRAME_W-1];
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          tx_sr_d   = '0;
          rx_sr_d   = '0;
          miso_d    = 1'b0;
        end else if (sck_rise) begin
          rx_sr_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
            rx_push      = 1'b1;
            tx_pop       = ~tx_empty;
            underrun_set = tx_empty;
            tx_sr_d      = tx_load;
          end
        end else if (sck_fall) begin
          // At a byte boundary the freshly loaded byte's MSB goes out unshifted.
          if (bit_cnt_q != '0) begin
            tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
            miso_d  = tx_sr_q[FRAME_W-2];
          end else begin
            miso_d = tx_sr_q[FRAME_W-1];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    overrun_set = rx_push & rx_full & ~rx_rd;
    overrun_d   = overrun_set  ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    underrun_d  = underrun_set ? 1'b1 : (err_clr ? 1'b0 : underrun_q);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_q     <= FLUSH_INIT;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  sync_fifo #(
    .WIDTH(FRAME_W),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .rst    (Rst),
    .wr_en  (tx_wr),
    .wr_data(tx_din),
    .rd_en  (tx_pop),
    .rd_data(tx_head),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  sync_fifo #(
    .WIDTH(FRAME_W),
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .rst    (Rst),
    .wr_en  (rx_push),
    .wr_data(rx_byte),
    .rd_en  (rx_rd),
    .rd_data(rx_dout),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  assign rx_avail    = ~rx_empty;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = busy_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;

endmodule
